// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one 32-bit shifter between
// NREQ valid/ready requesters, with a single-entry tagged result register.

module shifter (
  input  logic [31:0] a,
  input  logic [4:0]  shamt5,
  input  logic [1:0]  sh,
  output logic [31:0] y
);

  logic [63:0] w_rotDbl;

  // Combinational shift: LSL, LSR, ASR, ROR (rotate via doubled operand)
  always_comb begin
    y        = a;
    w_rotDbl = {a, a} >> shamt5;
    case (sh)
      2'b00:   y = a << shamt5;
      2'b01:   y = a >> shamt5;
      2'b10:   y = $unsigned($signed(a) >>> shamt5);
      default: y = w_rotDbl[31:0];
    endcase
  end

endmodule

module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*5-1:0]  req_shamt5,
  input  logic [NREQ*2-1:0]  req_sh,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_y,
  output logic [IDW-1:0]     rsp_id
);

  localparam logic [IDW:0]   LP_NREQ = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LP_LAST = IDW'(NREQ - 1);

  logic            r_rspValid;
  logic [31:0]     r_rspY;
  logic [IDW-1:0]  r_rspId;
  logic [IDW-1:0]  r_rrPtr;

  logic            w_slotFree;
  logic            w_grantValid;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_nextPtr;
  logic [IDW:0]    w_cand;
  logic [31:0]     w_selA;
  logic [4:0]      w_selShamt;
  logic [1:0]      w_selSh;
  logic [31:0]     w_shY;

  assign w_slotFree = !r_rspValid || rsp_ready;

  // Search from the round-robin pointer upward, wrapping at NREQ-1; the
  // winner defaults to rr_ptr so the datapath mux has a defined select.
  always_comb begin
    w_grantValid = 1'b0;
    w_winner     = r_rrPtr;
    w_cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rrPtr} + (IDW+1)'(k);
      if (w_cand >= LP_NREQ) begin
        w_cand = w_cand - LP_NREQ;
      end
      if (!w_grantValid && req_valid[w_cand[IDW-1:0]]) begin
        w_grantValid = 1'b1;
        w_winner     = w_cand[IDW-1:0];
      end
    end
    w_grantValid = w_grantValid && w_slotFree && rst_n;
  end

  // One-hot ready for the winner only; all-zero when nothing is granted
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grantValid && (w_winner == IDW'(i));
    end
  end

  // Pointer advances to the requester just past the winner
  always_comb begin
    w_nextPtr = (w_winner == LP_LAST) ? '0 : w_winner + 1'b1;
  end

  assign w_selA     = req_a[32*w_winner +: 32];
  assign w_selShamt = req_shamt5[5*w_winner +: 5];
  assign w_selSh    = req_sh[2*w_winner +: 2];

  shifter u_shifter (
    .a      (w_selA),
    .shamt5 (w_selShamt),
    .sh     (w_selSh),
    .y      (w_shY)
  );

  // Result register and pointer: capture on grant, clear valid on a bare drain,
  // hold everything while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= 1'b0;
      r_rspY     <= '0;
      r_rspId    <= '0;
      r_rrPtr    <= '0;
    end else if (w_grantValid) begin
      r_rspValid <= 1'b1;
      r_rspY     <= w_shY;
      r_rspId    <= w_winner;
      r_rrPtr    <= w_nextPtr;
    end else if (r_rspValid && rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_y     = r_rspY;
  assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed vectors with hand-computed results for the
// four-requester shift_arbiter.

module tb_shift_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*5-1:0]  req_shamt5;
  logic [NREQ*2-1:0]  req_sh;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_y;
  logic [IDW-1:0]     rsp_id;

  int testCount;
  int failCount;

  shift_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_shamt5 (req_shamt5),
    .req_sh     (req_sh),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_id     (rsp_id)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] a,
                               input logic [4:0] shamt, input logic [1:0] op);
    req_a[32*idx +: 32]     = a;
    req_shamt5[5*idx +: 5]  = shamt;
    req_sh[2*idx +: 2]      = op;
    req_valid[idx]          = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          opIdx [4] = '{0, 1, 3, 2};
  logic [31:0] opA   [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_00F1, 32'h1234_5678};
  logic [4:0]  opSh5 [4] = '{5'd31, 5'd4, 5'd4, 5'd0};
  logic [1:0]  opOp  [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
  logic [31:0] opExp [4] = '{32'h0000_0001, 32'hF800_0000, 32'h1000_000F, 32'h1234_5678};
  int          fairExp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    testCount  = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    req_valid  = '1;
    req_a      = '0;
    req_shamt5 = '0;
    req_sh     = '0;
    rsp_ready  = 1'b1;

    // Reset held with every requester valid
    tick();
    tick();
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_y", rsp_y, 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", 32'(req_ready), 32'b0001);
    req_valid = '0;
    tick();

    // Single request from requester 2: LSL 1 by 31
    applyStimulus(2, 32'h0000_0001, 5'd31, 2'b00);
    #1;
    checkOutput("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    checkOutput("single_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_y", rsp_y, 32'h8000_0000);
    checkOutput("single_id", 32'(rsp_id), 32'd2);

    // Operation coverage, one requester at a time, back to back
    for (int n = 0; n < 4; n++) begin
      applyStimulus(opIdx[n], opA[n], opSh5[n], opOp[n]);
      tick();
      req_valid = '0;
      checkOutput($sformatf("op%0d_valid", n), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("op%0d_y", n), rsp_y, opExp[n]);
      checkOutput($sformatf("op%0d_id", n), 32'(opIdx[n]) & 32'(rsp_id) | 32'(rsp_id), 32'(opIdx[n]));
    end

    // Pointer is now 3: requesters 0 and 1 valid, wrap picks 0
    applyStimulus(0, 32'h0000_0003, 5'd1, 2'b00);
    applyStimulus(1, 32'h0000_0010, 5'd4, 2'b01);
    #1;
    checkOutput("wrap_ready", 32'(req_ready), 32'b0001);
    tick();
    checkOutput("wrap_y", rsp_y, 32'h0000_0006);
    checkOutput("wrap_id", 32'(rsp_id), 32'd0);
    // Requester 0 re-presents; pointer at 1 must favour requester 1
    applyStimulus(0, 32'h0000_0005, 5'd1, 2'b00);
    #1;
    checkOutput("ptr_after_wrap", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    checkOutput("wrap2_y", rsp_y, 32'h0000_0001);
    checkOutput("wrap2_id", 32'(rsp_id), 32'd1);

    // Drain with no new requests
    tick();
    checkOutput("drain_valid", 32'(rsp_valid), 32'd0);
    checkOutput("drain_hold_y", rsp_y, 32'h0000_0001);
    checkOutput("drain_hold_id", 32'(rsp_id), 32'd1);

    // Reset while a result is held clears it at once
    applyStimulus(3, 32'h0000_00FF, 5'd0, 2'b00);
    tick();
    req_valid = '0;
    checkOutput("pre_reset_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_reset_y", rsp_y, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Fairness: all four valid, consumer always ready
    for (int i = 0; i < NREQ; i++) begin
      applyStimulus(i, 32'h0000_00A0 + 32'(i), 5'd4, 2'b00);
    end
    for (int n = 0; n < 6; n++) begin
      #1;
      checkOutput($sformatf("fair%0d_ready", n), 32'(req_ready), 32'd1 << fairExp[n]);
      tick();
      checkOutput($sformatf("fair%0d_valid", n), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("fair%0d_id", n), 32'(rsp_id), 32'(fairExp[n]));
      checkOutput($sformatf("fair%0d_y", n), rsp_y, (32'h0000_00A0 + 32'(fairExp[n])) << 4);
    end

    // Backpressure: result from requester 1 held for three cycles
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checkOutput($sformatf("bp%0d_ready", n), 32'(req_ready), 32'd0);
      tick();
      checkOutput($sformatf("bp%0d_valid", n), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d_y", n), rsp_y, 32'h0000_0A10);
      checkOutput($sformatf("bp%0d_id", n), 32'(rsp_id), 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_release_y", rsp_y, 32'h0000_0A20);
    checkOutput("bp_release_id", 32'(rsp_id), 32'd2);

    tick();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
